// File: rtl/morse_encoder.sv
// Morse encoder: sends five 2-bit dot/line symbols as timed marks and gaps.
// Registered outputs; one FSM clocks both the control state and the outputs.
module morse_encoder #(
  parameter int DOT_TICKS  = 2,
  parameter int LINE_TICKS = 6,
  parameter int GAP_TICKS  = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] code,
  output logic       morse_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] sym_idx
);

  localparam int MAXML =
    (DOT_TICKS > LINE_TICKS) ? DOT_TICKS : LINE_TICKS;
  localparam int MAXT =
    (MAXML > GAP_TICKS) ? MAXML : GAP_TICKS;
  localparam int CW = $clog2(MAXT + 1);

  localparam logic [CW-1:0] DOT_C  = CW'(DOT_TICKS);
  localparam logic [CW-1:0] LINE_C = CW'(LINE_TICKS);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP_TICKS);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MARK,
    GAP,
    DONE
  } state_e;

  state_e        state_q;
  logic [9:0]    shreg_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic          mo_q;
  logic          busy_q;
  logic          done_q;

  logic          last_slot;

  assign last_slot = (idx_q == 3'd4);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      mo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= code;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          unique case (1'b1)
            (shreg_q[9:8] == 2'b01): begin
              cnt_q   <= DOT_C;
              mo_q    <= 1'b1;
              state_q <= MARK;
            end
            (shreg_q[9:8] == 2'b11): begin
              cnt_q   <= LINE_C;
              mo_q    <= 1'b1;
              state_q <= MARK;
            end
            default: begin
              // empty or invalid slot: no mark, no gap
              shreg_q <= shreg_q << 2;
              if (last_slot) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                idx_q   <= idx_q + 3'd1;
                state_q <= FETCH;
              end
            end
          endcase
        end
        MARK: begin
          if (cnt_q == ONE_C) begin
            mo_q    <= 1'b0;
            cnt_q   <= GAP_C;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - ONE_C;
          end
        end
        GAP: begin
          if (cnt_q == ONE_C) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q << 2;
            if (last_slot) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= FETCH;
            end
          end else begin
            cnt_q <= cnt_q - ONE_C;
          end
        end
        DONE: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign morse_out = mo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sym_idx   = idx_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed and random codes against a
// cycle-timeline model built from the symbol timing rules.
module tb_morse_encoder;

  localparam int DOT  = 2;
  localparam int LINE = 6;
  localparam int GAP  = 2;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [9:0] code;
  logic       morse_out;
  logic       busy;
  logic       done;
  logic [2:0] sym_idx;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       b;
    logic       m;
    logic       d;
    logic [2:0] idx;
    bit         idx_dc;
  } exp_t;

  exp_t exp_q[$];

  morse_encoder #(
    .DOT_TICKS (DOT),
    .LINE_TICKS(LINE),
    .GAP_TICKS (GAP)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .code     (code),
    .morse_out(morse_out),
    .busy     (busy),
    .done     (done),
    .sym_idx  (sym_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic b, logic m, logic d,
                              logic [2:0] idx, bit dc);
    exp_t e;
    e.b = b; e.m = m; e.d = d; e.idx = idx; e.idx_dc = dc;
    return e;
  endfunction

  // Timeline for cycles 1.. after the latching edge, ending in one IDLE cycle.
  task automatic push_model(input logic [9:0] c);
    logic [1:0] s;
    int len;
    for (int k = 0; k < 5; k++) begin
      s = c[9-2*k -: 2];
      exp_q.push_back(mk(1, 0, 0, 3'(k), 0));
      len = (s == 2'b01) ? DOT : (s == 2'b11) ? LINE : 0;
      if (len > 0) begin
        for (int t = 0; t < len; t++) exp_q.push_back(mk(1, 1, 0, 3'(k), 0));
        for (int t = 0; t < GAP; t++) exp_q.push_back(mk(1, 0, 0, 3'(k), 0));
      end
    end
    exp_q.push_back(mk(0, 0, 1, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
  endtask

  task automatic run(input logic [9:0] c, input bit hold,
                     input int pulse_at, input string tag);
    int n1;
    exp_q.delete();
    push_model(c);
    n1 = exp_q.size();
    if (hold) push_model(c);
    @(negedge clock);
    code  = c;
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      if (!hold || i == n1) start = 1'b0;
      if (i == pulse_at) begin
        start = 1'b1;
        code  = ~c;
      end
      chk($sformatf("%s busy c%0d", tag, i + 1), 8'(busy), 8'(exp_q[i].b));
      chk($sformatf("%s morse c%0d", tag, i + 1), 8'(morse_out),
          8'(exp_q[i].m));
      chk($sformatf("%s done c%0d", tag, i + 1), 8'(done), 8'(exp_q[i].d));
      if (!exp_q[i].idx_dc)
        chk($sformatf("%s idx c%0d", tag, i + 1), 8'(sym_idx),
            8'(exp_q[i].idx));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [9:0] rc;
    resetn = 1'b0;
    start  = 1'b0;
    code   = '0;
    #12;
    chk("rst morse", 8'(morse_out), 8'h0);
    chk("rst busy", 8'(busy), 8'h0);
    chk("rst done", 8'(done), 8'h0);
    chk("rst idx", 8'(sym_idx), 8'h0);
    @(negedge clock);
    resetn = 1'b1;

    run(10'b01_11_00_00_00, 0, -1, "dotline");
    run(10'b00_00_00_00_00, 0, -1, "zero");
    run(10'b11_11_11_11_11, 0, -1, "lines");
    run(10'b10_01_00_00_00, 0, -1, "skipdot");
    run(10'b01_01_01_01_01, 0, -1, "dots");
    run(10'b11_10_01_00_11, 0, 2, "busystart");
    run(10'b00_00_00_00_01, 0, 3, "lastdot");
    run(10'b01_00_11_00_00, 1, -1, "hold");

    for (int r = 0; r < 20; r++) begin
      rc = 10'($urandom);
      run(rc, 0, (r % 3 == 0) ? int'($urandom_range(1, 8)) : -1,
          $sformatf("rnd%0d", r));
    end

    // reset in the middle of a line mark
    @(negedge clock);
    code  = 10'b11_11_11_11_11;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre-rst morse", 8'(morse_out), 8'h1);
    #2 resetn = 1'b0;
    #1;
    chk("async morse", 8'(morse_out), 8'h0);
    chk("async busy", 8'(busy), 8'h0);
    chk("async idx", 8'(sym_idx), 8'h0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      chk($sformatf("postrst morse c%0d", i), 8'(morse_out), 8'h0);
      chk($sformatf("postrst busy c%0d", i), 8'(busy), 8'h0);
    end

    run(10'b11_01_00_00_00, 0, -1, "afterrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
